// File: rtl/alu_pkg.sv
// Shared types for seq_alu: opcodes, FSM states and the bit positions inside the flags bus.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_SHL = 3'b110,
        OP_MUL = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int FLAG_W   = 4;
    localparam int FLAG_NEG = 3;
    localparam int FLAG_Z   = 2;
    localparam int FLAG_C   = 1;
    localparam int FLAG_V   = 0;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: one partial-product step per cycle, N steps per operation.
// Only instantiated when SEQ_ALU_MUL_EN is defined.
module alu_mul_seq #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             done,
    output logic [2*N-1:0]   product
);

    localparam int CW = $clog2(N);

    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic [2*N-1:0] acc_step;

    // done marks the cycle whose edge retires the last step, so product already includes it
    assign done    = busy_q && (cnt_q == CW'(N - 1));
    assign product = acc_step;

    always_comb begin
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            acc_d    = '0;
            mcand_d  = {{N{1'b0}}, a};
            mplier_d = b;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            busy_d   = !done;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU with registered result/flags; single-cycle ops plus an optional
// multi-cycle MUL compiled in with SEQ_ALU_MUL_EN.
module seq_alu
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      a,
    input  logic [N-1:0]      b,
    input  logic [2:0]        op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      result,
    output logic [FLAG_W-1:0] flags,
    output logic              err
);

    localparam int SW = $clog2(N);

    state_e              state_q, state_d;
    logic [N-1:0]        result_q, result_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;
    logic                err_q, err_d;

    opcode_e             op_e;
    logic                accept;
    logic [N:0]          sum, diff, shl_w;
    logic [N-1:0]        alu_res;
    logic                alu_c, alu_v, alu_err;

    function automatic logic [FLAG_W-1:0] make_flags(input logic [N-1:0] r,
                                                     input logic c, input logic v);
        logic [FLAG_W-1:0] f;
        f           = '0;
        f[FLAG_NEG] = r[N-1];
        f[FLAG_Z]   = (r == '0);
        f[FLAG_C]   = c;
        f[FLAG_V]   = v;
        return f;
    endfunction

    assign op_e      = opcode_e'(op);
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign flags     = flags_q;
    assign err       = err_q;

`ifdef SEQ_ALU_MUL_EN
    logic           mul_start;
    logic           mul_done;
    logic [2*N-1:0] mul_product;

    alu_mul_seq #(.N(N)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );
`endif

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
        // bit N of the widened shift is the last bit pushed out of the top (0 when amount is 0)
        shl_w   = {1'b0, a} << b[SW-1:0];
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (op_e)
            OP_ADD: begin
                alu_res = sum[N-1:0];
                alu_c   = sum[N];
                alu_v   = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_SUB: begin
                alu_res = diff[N-1:0];
                alu_c   = diff[N];
                alu_v   = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SHL: begin
                alu_res = shl_w[N-1:0];
                alu_c   = shl_w[N];
            end
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = err_q;
`ifdef SEQ_ALU_MUL_EN
        mul_start = 1'b0;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE && out_ready) state_d = IDLE;
                if (accept) begin
`ifdef SEQ_ALU_MUL_EN
                    if (op_e == OP_MUL) begin
                        state_d   = MUL;
                        mul_start = 1'b1;
                    end else
`endif
                    begin
                        state_d  = DONE;
                        result_d = alu_res;
                        flags_d  = make_flags(alu_res, alu_c, alu_v);
                        err_d    = alu_err;
                    end
                end
            end
`ifdef SEQ_ALU_MUL_EN
            MUL: begin
                if (mul_done) begin
                    state_d  = DONE;
                    result_d = mul_product[N-1:0];
                    flags_d  = make_flags(mul_product[N-1:0], |mul_product[2*N-1:N], 1'b0);
                    err_d    = 1'b0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner vectors, random ops against an
// arithmetic reference model, output stall, reset mid-operation and back-to-back issue.
module tb_seq_alu;

    localparam int N = 8;
`ifdef SEQ_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam int MUL_LAT = MUL_EN ? N + 1 : 1;

    typedef struct packed {
        logic [7:0] res;
        logic [3:0] flags;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] op = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] result;
    logic [3:0] flags;
    logic       err;

    int checks = 0;
    int passed = 0;

    seq_alu #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference model: integer arithmetic straight from the opcode definitions.
    function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        int   ux, uy, sx, sy, full, r, amt;
        bit   c, v;
        exp_t e;
        ux = x; uy = y;
        sx = $signed(x); sy = $signed(y);
        c = 0; v = 0; r = 0;
        e.err = 1'b0;
        case (o)
            3'd0: begin full = ux + uy; r = full % 256; c = (full > 255);
                        v = (sx + sy > 127) || (sx + sy < -128); end
            3'd1: begin r = (ux - uy + 256) % 256; c = (ux >= uy);
                        v = (sx - sy > 127) || (sx - sy < -128); end
            3'd2: r = ux & uy;
            3'd3: r = ux | uy;
            3'd4: r = ux ^ uy;
            3'd5: r = (sx < sy) ? 1 : 0;
            3'd6: begin amt = uy % 8; r = (ux << amt) % 256;
                        c = (amt == 0) ? 0 : ((ux >> (8 - amt)) & 1) != 0; end
            default: begin
                if (MUL_EN) begin full = ux * uy; r = full % 256; c = (full > 255); end
                else begin r = 0; e.err = 1'b1; end
            end
        endcase
        e.res   = r[7:0];
        e.flags = {e.res[7], (e.res == 8'h00), c, v};
        return e;
    endfunction

    // Drives one command, waits for its acceptance and result; scrambles inputs after accept.
    task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                          output exp_t got, output int lat);
        int w;
        w = 0;
        op = o; a = x; b = y; in_valid = 1'b1;
        while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
        lat = 1;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        got = {result, flags, err};
    endtask

    task automatic settle();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({out_valid, result, flags, err} !== 14'd0)
            $display("FAIL reset_outputs got ov=%b res=%h fl=%b err=%b want all zero",
                     out_valid, result, flags, err);
        else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
        else passed++;
    endtask

    task automatic test_directed();
        exp_t got;
        int   lat;
        settle();
        run_op(3'd0, 8'h7F, 8'h01, got, lat);
        checks++;
        if (got !== {8'h80, 4'b1001, 1'b0} || lat !== 1)
            $display("FAIL add_overflow got %h/%b/%b lat %0d want 80/1001/0 lat 1",
                     got.res, got.flags, got.err, lat);
        else passed++;
        run_op(3'd1, 8'h00, 8'h01, got, lat);
        checks++;
        if (got !== {8'hFF, 4'b1000, 1'b0} || lat !== 1)
            $display("FAIL sub_borrow got %h/%b lat %0d want FF/1000 lat 1", got.res, got.flags, lat);
        else passed++;
        run_op(3'd1, 8'h05, 8'h05, got, lat);
        checks++;
        if (got !== {8'h00, 4'b0110, 1'b0})
            $display("FAIL sub_zero got %h/%b want 00/0110", got.res, got.flags);
        else passed++;
        run_op(3'd5, 8'hFF, 8'h01, got, lat);
        checks++;
        if (got !== {8'h01, 4'b0000, 1'b0})
            $display("FAIL slt_signed got %h/%b want 01/0000", got.res, got.flags);
        else passed++;
        run_op(3'd7, 8'h10, 8'h20, got, lat);
        checks++;
        if (got !== (MUL_EN ? {8'h00, 4'b0110, 1'b0} : {8'h00, 4'b0100, 1'b1}) || lat !== MUL_LAT)
            $display("FAIL mul_corner got %h/%b/%b lat %0d want lat %0d",
                     got.res, got.flags, got.err, lat, MUL_LAT);
        else passed++;
    endtask

    task automatic test_random();
        exp_t       got, exp;
        int         lat;
        logic [2:0] o;
        logic [7:0] x, y;
        settle();
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom); x = 8'($urandom); y = 8'($urandom);
            if (i < 8) o = 3'(i);
            exp = model(o, x, y);
            run_op(o, x, y, got, lat);
            checks++;
            if (got !== exp || lat !== ((o == 3'd7) ? MUL_LAT : 1))
                $display("FAIL random op=%0d a=%h b=%h got %h/%b/%b lat %0d want %h/%b/%b",
                         o, x, y, got.res, got.flags, got.err, lat, exp.res, exp.flags, exp.err);
            else passed++;
        end
    endtask

    task automatic test_stall();
        exp_t got;
        int   lat;
        int   bad;
        settle();
        out_ready = 1'b0;
        run_op(3'd6, 8'h81, 8'h01, got, lat);
        checks++;
        if (got !== {8'h02, 4'b0010, 1'b0} || lat !== 1)
            $display("FAIL shl_carry got %h/%b lat %0d want 02/0010 lat 1", got.res, got.flags, lat);
        else passed++;
        op = 3'd0; a = 8'h03; b = 8'h04; in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || result !== 8'h02 || flags !== 4'b0010 || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL stall_hold got %0d unstable cycles want 0", bad);
        else passed++;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL release_in_ready got %b want 1", in_ready);
        else passed++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h07 || flags !== 4'b0000)
            $display("FAIL release_accept got ov=%b %h/%b want 1 07/0000", out_valid, result, flags);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL drain_idle got ov=%b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_mul_reset();
        int seen;
        settle();
        out_ready = 1'b0;
        op = 3'd7; a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, result, flags, err} !== 14'd0)
            $display("FAIL mul_reset_clear got ov=%b res=%h fl=%b err=%b want all zero",
                     out_valid, result, flags, err);
        else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL mul_reset_in_ready got %b want 1", in_ready);
        else passed++;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen != 0) $display("FAIL mul_reset_discard got %0d valid cycles want 0", seen);
        else passed++;
    endtask

    task automatic test_back_to_back();
        exp_t       exp;
        logic [2:0] o;
        logic [7:0] x, y;
        int         bad;
        settle();
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            o = (i % 2 == 0) ? 3'd0 : 3'd4;
            x = 8'($urandom); y = 8'($urandom);
            exp = model(o, x, y);
            op = o; a = x; b = y; in_valid = 1'b1;
            #1;
            if (in_ready !== 1'b1) bad++;
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || {result, flags, err} !== exp) bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0) $display("FAIL back_to_back got %0d bad cycles want 0", bad);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL b2b_drain got ov=%b want 0", out_valid);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_mul_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
